// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - instruction register with DEPTH-entry prefetch queue
// Head entry is split into op_code/address and handed to decode via valid/ready.
module instr_queue #(
  parameter int ADDRESS_WIDTH     = 5,
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int OP_CODE_WIDTH     = INSTRUCTION_WIDTH - ADDRESS_WIDTH,
  parameter int DEPTH             = 4,
  parameter int CNT_WIDTH         = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_CODE_WIDTH-1:0]     op_code,
  output logic [ADDRESS_WIDTH-1:0]     address,
  output logic [CNT_WIDTH-1:0]         count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]         wr_ptr;
  logic [PTR_WIDTH-1:0]         rd_ptr;
  logic [INSTRUCTION_WIDTH-1:0] head;
  logic                         push;
  logic                         pop;

  assign in_ready  = (count != CNT_WIDTH'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Fields read as zero while empty so decode never sees a stale entry.
  assign op_code = out_valid ? head[INSTRUCTION_WIDTH-1:ADDRESS_WIDTH] : '0;
  assign address = out_valid ? head[ADDRESS_WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (pop && !push) count <= count - CNT_WIDTH'(1);
    end
  end

  // Storage carries no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= instruction;
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed scoreboard bench for instr_queue
module tb_instr_queue;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instruction;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] op_code;
  logic [4:0] address;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];

  instr_queue dut (
    .clk(clk), .n_rst(n_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_code(op_code), .address(address), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] h;
    h = (sb.size() != 0) ? sb[0] : 8'h00;
    chk({tag, ".count"},     32'(count),     32'(sb.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(sb.size() != 4));
    chk({tag, ".op_code"},   32'(op_code),   32'(h[7:5]));
    chk({tag, ".address"},   32'(address),   32'(h[4:0]));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic iv, input logic [7:0] ins, input logic ordy,
                       input logic fl, input string tag);
    logic acc, popd;
    in_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
    acc  = iv && (sb.size() != 4) && !fl;
    popd = ordy && (sb.size() != 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else begin
      if (popd) void'(sb.pop_front());
      if (acc)  sb.push_back(ins);
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    check_state(tag);
  endtask

  initial begin
    n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = 8'h00;
    #12;
    check_state("reset_init");
    n_rst = 1'b1;

    // Single push and pop
    cycle(1'b1, 8'hA7, 1'b0, 1'b0, "push_a7");
    chk("a7.op_code", 32'(op_code), 32'h5);
    chk("a7.address", 32'(address), 32'h07);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "pop_a7");

    // Fill, ignored fifth push, drain in order
    cycle(1'b1, 8'h21, 1'b0, 1'b0, "fill0");
    cycle(1'b1, 8'h42, 1'b0, 1'b0, "fill1");
    cycle(1'b1, 8'h63, 1'b0, 1'b0, "fill2");
    cycle(1'b1, 8'h84, 1'b0, 1'b0, "fill3");
    chk("full.count", 32'(count), 32'd4);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, "fill_over");
    chk("full.head_op", 32'(op_code), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("drained.count", 32'(count), 32'd0);

    // Steady push/pop at count 2 across pointer wrap
    cycle(1'b1, 8'h10, 1'b0, 1'b0, "wrap_pre0");
    cycle(1'b1, 8'h11, 1'b0, 1'b0, "wrap_pre1");
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h12 + i), 1'b1, 1'b0, "wrap");
    chk("wrap.head", 32'({op_code, address}), 32'h1A);

    // Flush priority over push and pop
    cycle(1'b1, 8'h30, 1'b0, 1'b0, "pre_flush");
    check_state("flush_cycle");
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, "flush");
    chk("flush.count", 32'(count), 32'd0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, "post_flush");
    chk("post_flush.head", 32'({op_code, address}), 32'h55);

    // Backpressure hold on a full queue
    cycle(1'b1, 8'h56, 1'b0, 1'b0, "bp_fill1");
    cycle(1'b1, 8'h57, 1'b0, 1'b0, "bp_fill2");
    cycle(1'b1, 8'h58, 1'b0, 1'b0, "bp_fill3");
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC9, 1'b0, 1'b0, "bp_hold");
    cycle(1'b1, 8'hC9, 1'b1, 1'b0, "bp_pop");
    chk("bp_pop.count", 32'(count), 32'd3);
    cycle(1'b1, 8'hC9, 1'b0, 1'b0, "bp_accept");
    chk("bp_accept.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp_drain");

    // Asynchronous reset mid-cycle with two entries queued
    cycle(1'b1, 8'h9A, 1'b0, 1'b0, "rst_pre0");
    cycle(1'b1, 8'h9B, 1'b0, 1'b0, "rst_pre1");
    #2;
    n_rst = 1'b0;
    #1;
    sb.delete();
    check_state("reset_async");
    #3;
    n_rst = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction register with a DEPTH-entry prefetch queue. It sits between instruction fetch and the control unit and lets fetch run ahead of decode. Each stored instruction is split into an op_code field and an address field. The head entry is presented to decode with a valid/ready handshake, and a flush discards all queued instructions on a branch or jump.

## Interface
- ADDRESS_WIDTH, 5, width of the address field (instruction LSBs)
- INSTRUCTION_WIDTH, 8, width of one instruction word
- OP_CODE_WIDTH, INSTRUCTION_WIDTH - ADDRESS_WIDTH, width of the op_code field (instruction MSBs)
- DEPTH, 4, number of queue entries; must be a power of two, at least 2
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  input  1  clock; all state updates on the rising edge
- n_rst  input  1  asynchronous, active-low reset
- flush  input  1  discard all entries; synchronous
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept; equals (count != DEPTH)
- instruction  input  INSTRUCTION_WIDTH  instruction word from fetch
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  decode consumes the head entry
- op_code  output  OP_CODE_WIDTH  head instruction[INSTRUCTION_WIDTH-1:ADDRESS_WIDTH]; all zeros when empty
- address  output  ADDRESS_WIDTH  head instruction[ADDRESS_WIDTH-1:0]; all zeros when empty
- count  output  CNT_WIDTH  number of occupied entries, 0..DEPTH

## Operation
- Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus a count register. Pointers wrap from DEPTH-1 to 0 by natural overflow.
- **push**: in_valid && in_ready. Writes instruction at wr_ptr and increments wr_ptr.
- **pop**: out_valid && out_ready. Increments rd_ptr. The popped entry is not cleared.
- **count update**: push only gives +1; pop only gives -1; push and pop together leave count unchanged. Simultaneous push and pop is legal whenever 0 < count < DEPTH.
- **Full** (count == DEPTH): in_ready = 0 and in_valid is ignored. No write-through, even if a pop occurs in the same cycle.
- **Empty** (count == 0): out_valid = 0, op_code = 0, address = 0, and out_ready is ignored. No bypass: an instruction pushed into an empty queue appears on the outputs one cycle later.
- **flush**: takes priority over push and pop in the same cycle. Next state is wr_ptr = rd_ptr = 0 and count = 0. Storage contents are unchanged but unobservable. in_ready and out_valid still reflect the current state during the flush cycle.
- **Outputs**: op_code, address and out_valid are combinational from the head entry (rd_ptr) and count. in_ready is combinational from count.
- **Reset** (n_rst low, any time including mid-operation): wr_ptr, rd_ptr and count go to 0 immediately. After reset, out_valid = 0, in_ready = 1, op_code = 0, address = 0, count = 0. Storage is not reset.

## Timing
- Write-to-read latency: 1 cycle. A push accepted at edge N gives out_valid = 1 with that instruction's fields after edge N.
- Throughput: one push and one pop per cycle, sustained.
- count, in_ready and out_valid update only on the clock edge or on asynchronous reset assertion.
- Handshake: fetch must hold instruction stable while in_valid && !in_ready. Decode samples op_code/address in any cycle where out_valid is high. The head stays stable until the edge at which it is popped.
- Reset deassertion is asynchronous in effect. The first push is accepted on the first rising edge with n_rst high.

## Test plan
All scenarios use the default parameters (ADDRESS_WIDTH=5, INSTRUCTION_WIDTH=8, DEPTH=4).
- **Reset**: assert n_rst=0 mid-cycle with 2 entries queued -> immediately count=0, out_valid=0, in_ready=1, op_code=3'b000, address=5'b00000.
- **Single push**: push 8'hA7 into an empty queue -> the next cycle shows out_valid=1, op_code=3'b101, address=5'b00111, count=1. Pop it -> count=0, outputs back to zero.
- **Fill**: push 8'h21, 8'h42, 8'h63, 8'h84 with out_ready=0 -> count=4, in_ready=0. A fifth push of 8'hFF is ignored. Then pop 4 -> heads in order 001/00001, 010/00010, 011/00011, 100/00100.
- **Simultaneous push/pop with wrap**: hold count=2 while pushing and popping every cycle for 10 cycles, using incrementing instructions -> count stays 2, output order matches input order across pointer wrap, and nothing is dropped or duplicated.
- **Flush priority**: with count=3, assert flush, in_valid=1 and out_ready=1 in the same cycle -> the next cycle shows count=0, out_valid=0, op_code=0, address=0. The instruction offered in the flush cycle is not stored.
- **Backpressure hold**: full queue with in_valid=1 for 3 cycles, then one pop -> the held instruction is accepted on the edge after the pop cycle, count returns to 4, and FIFO order is preserved.
